calc_alu_sequencer: RTL and testbench

//  Multi-cycle arithmetic engine for the keypad calculator. Replaces the single-cycle
//  +,-,*,/ block with one sequenced datapath: one cycle for add/sub, iterative

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_iter_unit.sv | 63 ++++++
 rtl/calc_alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator arithmetic engine:
// opcodes, error pattern and sequencer state encoding.
package calc_pkg;

  localparam int CALC_WIDTH = 16;

  localparam logic [CALC_WIDTH-1:0] ERR_PATTERN_DEF = 16'hEEEE;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    DIV    = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Shared shift register + WIDTH+1 bit adder for shift-add multiply and restoring divide.
// Ports: clk, rst, load (capture op_a/op_b), step (one iteration), div_mode, hi/lo state.
module calc_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  // mul: hi accumulates, product bits shift down into lo.
  // div: {hi,lo} shifts left, trial subtract decides each quotient bit.
  always_comb begin
    x    = '0;
    y    = '0;
    s    = '0;
    hi_n = hi;
    lo_n = lo;
    if (div_mode) begin
      x = {hi, lo[WIDTH-1]};
      y = {1'b0, b_q};
      s = x - y;
      // hi < divisor always, so bit WIDTH is a clean borrow flag
      hi_n = s[WIDTH] ? x[WIDTH-1:0] : s[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ~s[WIDTH]};
    end else begin
      x = {1'b0, hi};
      y = lo[0] ? {1'b0, b_q} : '0;
      s = x + y;
      hi_n = s[WIDTH:1];
      lo_n = {s[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= op_a;
      b_q <= op_b;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle +,-,*,/ engine for the keypad calculator.
// Ports: clk, rst, start/opcode/op1/op2 in; busy, done, result, remainder, error out.
module calc_alu_sequencer
  import calc_pkg::*;
#(
  parameter int             WIDTH       = CALC_WIDTH,
  parameter logic [WIDTH-1:0] ERR_PATTERN = ERR_PATTERN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_n;
  logic [3:0]       opc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             fin;
  logic             err_n;
  logic [WIDTH-1:0] result_n;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             it_step;
  logic             it_div;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  // FINISH is the done cycle, so a new request is taken there too
  assign accept  = start && (state == IDLE || state == FINISH);
  assign last    = (cnt == CW'(WIDTH));
  assign it_div  = (state == DIV);
  assign it_step = (state == MUL || state == DIV) && !last;
  assign busy    = (state == ADDSUB || state == MUL || state == DIV);
  assign done    = (state == FINISH);

  calc_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (it_step),
    .div_mode(it_div),
    .op_a    (op1),
    .op_b    (op2),
    .hi      (it_hi),
    .lo      (it_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Single-cycle outcomes (add, sub, bad opcode, div by zero)
  // all pass through ADDSUB so they share the 2-cycle latency.
  always_comb begin
    state_n  = state;
    fin      = 1'b0;
    err_n    = 1'b0;
    result_n = '0;
    rem_n    = '0;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    unique case (state)
      IDLE, FINISH: begin
        state_n = IDLE;
        if (start) begin
          unique case (1'b1)
            (opcode == OP_MUL):
              state_n = MUL;
            (opcode == OP_DIV && op2 != '0):
              state_n = DIV;
            default:
              state_n = ADDSUB;
          endcase
        end
      end
      ADDSUB: begin
        fin     = 1'b1;
        state_n = FINISH;
        case (opc_q)
          OP_ADD: begin
            err_n    = sum[WIDTH];
            result_n = sum[WIDTH-1:0];
          end
          OP_SUB: begin
            err_n    = diff[WIDTH];
            result_n = diff[WIDTH-1:0];
          end
          default: err_n = 1'b1;
        endcase
      end
      MUL: begin
        if (last) begin
          fin      = 1'b1;
          state_n  = FINISH;
          err_n    = |it_hi;
          result_n = it_lo;
        end
      end
      DIV: begin
        if (last) begin
          fin      = 1'b1;
          state_n  = FINISH;
          result_n = it_lo;
          rem_n    = it_hi;
        end
      end
      default: state_n = IDLE;
    endcase
    if (err_n) begin
      result_n = ERR_PATTERN;
      rem_n    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      result    <= '0;
      remainder <= '0;
      error     <= 1'b0;
    end else begin
      if (accept) begin
        opc_q <= opcode;
        a_q   <= op1;
        b_q   <= op2;
        cnt   <= '0;
        error <= 1'b0;
      end else if (it_step) begin
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        result    <= result_n;
        remainder <= rem_n;
        error     <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Scoreboard bench for calc_alu_sequencer: directed cases then random ops.
// Driver pushes model results; monitor pops and compares on each done pulse.
module tb_calc_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] result;
  logic [15:0] remainder;

  calc_alu_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .op1      (op1),
    .op2      (op2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .remainder(remainder),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        err;
    int          st;
    int          cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t model(logic [3:0] opc, logic [15:0] a,
                                 logic [15:0] b, int st);
    exp_t e;
    int unsigned x;
    e.res = '0;
    e.rem = '0;
    e.err = 1'b0;
    e.st  = st;
    e.cyc = st + 2;
    case (opc)
      4'hA: begin
        x = a + b;
        if (x > 32'hFFFF) e.err = 1'b1;
        else e.res = x[15:0];
      end
      4'hB: begin
        if (a < b) e.err = 1'b1;
        else e.res = a - b;
      end
      4'hC: begin
        x = a * b;
        e.cyc = st + 18;
        if (x > 32'hFFFF) e.err = 1'b1;
        else e.res = x[15:0];
      end
      4'hD: begin
        if (b == 0) begin
          e.err = 1'b1;
        end else begin
          e.res = a / b;
          e.rem = a % b;
          e.cyc = st + 18;
        end
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) begin
      e.res = 16'hEEEE;
      e.rem = '0;
    end
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got 1 want 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("remainder", remainder, e.rem);
          chk("error", error, e.err);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", busy, 0);
        end
      end else if (q.size() > 0) begin
        if (cyc > q[0].st) chk("busy_running", busy, 1);
        else chk("busy_idle", busy, 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge of the done cycle
  task automatic issue(logic [3:0] opc, logic [15:0] a,
                       logic [15:0] b, bit noise);
    start  = 1'b1;
    opcode = opc;
    op1    = a;
    op2    = b;
    q.push_back(model(opc, a, b, cyc));
    @(negedge clk);
    start  = 1'b0;
    opcode = 4'($urandom);
    op1    = 16'($urandom);
    op2    = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      if (noise && $urandom_range(0, 2) == 0) begin
        start  = 1'b1;
        opcode = 4'($urandom);
        op1    = 16'($urandom);
        op2    = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    errors++;
    $display("FAIL timeout got no_done want done at cycle %0d", cyc);
    q.delete();
    do_reset();
  endtask

  initial begin
    int st;
    int r;
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_remainder", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(4'hA, 16'h0012, 16'h0034, 0);
    issue(4'hA, 16'hFFFF, 16'h0001, 0);
    issue(4'hB, 16'h0005, 16'h0007, 0);
    issue(4'hB, 16'h0007, 16'h0005, 0);
    issue(4'hC, 16'h00FF, 16'h0101, 0);
    issue(4'hC, 16'h0100, 16'h0100, 0);
    issue(4'hD, 16'h0064, 16'h0007, 0);
    issue(4'hD, 16'h1234, 16'h0000, 0);
    issue(4'h3, 16'h0001, 16'h0002, 0);
    issue(4'hC, 16'h0123, 16'h00AB, 1);
    issue(4'hD, 16'hFFFF, 16'h0001, 1);

    // abort a divide mid-flight
    start  = 1'b1;
    opcode = 4'hD;
    op1    = 16'h0064;
    op2    = 16'h0007;
    st     = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < st + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_error", error, 0);
    chk("abort_remainder", remainder, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(4'hA, 16'h1111, 16'h2222, 0);

    repeat (150) begin
      r = $urandom_range(0, 9);
      a = 16'($urandom) >> $urandom_range(0, 15);
      b = 16'($urandom) >> $urandom_range(0, 15);
      case (r)
        0, 1: opc = 4'hA;
        2, 3: opc = 4'hB;
        4, 5: opc = 4'hC;
        6, 7: opc = 4'hD;
        8: begin
          opc = 4'($urandom_range(0, 11));
          if (opc > 4'h9) opc = opc + 4'h4;
        end
        default: begin
          opc = 4'hD;
          b   = '0;
        end
      endcase
      issue(opc, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
